// File: rtl/preload_sequencer_pkg.sv
// Shared types and constants for the pre-load sequencer and its stream writers.
package preload_pkg;

  localparam int DEPTH          = 64;
  localparam int ADDR_W         = $clog2(DEPTH);
  localparam int W_W            = 8;
  localparam int A_W            = 7;
  localparam int SETTLE_CYCLES  = 4;
  localparam int PRELOAD_CYCLES = 3;
  localparam int CAL_CYCLES     = 22;
  // Wide enough for the longest phase reload value.
  localparam int PH_W           = $clog2(CAL_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    PRELOAD,
    CAL,
    FIN
  } state_t;

  // Down-counter reload value for a timed state; it counts N-1..0, so the state lasts N cycles.
  function automatic logic [PH_W-1:0] phase_reload(input state_t s);
    case (s)
      SETTLE:  return PH_W'(SETTLE_CYCLES - 1);
      PRELOAD: return PH_W'(PRELOAD_CYCLES - 1);
      CAL:     return PH_W'(CAL_CYCLES - 1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/preload_sequencer_stream_addr_writer.sv
// Accepts one valid/ready byte stream and turns it into registered (data, address) write pairs.
module stream_addr_writer #(
  parameter int DW     = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [DW-1:0]     i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DW-1:0]     o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_full
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W:0]   r_cnt;
  logic [DW-1:0]     r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              w_fire;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_ready = i_en && (r_cnt < FULL_CNT);
  assign w_fire  = i_valid && o_ready;
  assign o_data  = r_data;
  assign o_addr  = r_addr;

  // Count accepted beats (saturating at DEPTH via ready) and register the write pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
    end else if (w_fire) begin
      r_cnt  <= r_cnt + (ADDR_W + 1)'(1);
      r_data <= i_data;
      r_addr <= r_cnt[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/preload_sequencer.sv
// Drives one tile through load, settle, pre-load and compute phases.
//
// state   | meaning
// IDLE    | waiting for start; counters held clear
// LOAD    | accepting weight/activation beats until both memories hold DEPTH entries
// SETTLE  | load_mem_done high, waiting for the pre-load unit to settle
// PRELOAD | PreLoad_CWeight high, one cycle per CPE in a column
// CAL     | Cal high for the pipeline fill/compute/drain window
// FIN     | single-cycle done pulse, then back to IDLE
module preload_sequencer
  import preload_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [W_W-1:0]    w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [A_W-1:0]    a_data,
  input  logic              a_valid,
  output logic              a_ready,
  output logic [W_W-1:0]    Weight,
  output logic [ADDR_W-1:0] Weight_Mem_Address_in,
  output logic [A_W-1:0]    Activation,
  output logic [ADDR_W-1:0] Activation_Mem_Address_in,
  output logic              load_mem_done,
  output logic              PreLoad_CWeight,
  output logic              Cal,
  output logic              busy,
  output logic              done
);

  state_t          r_state;
  state_t          w_next;
  logic [PH_W-1:0] r_phase;
  logic            w_phase_end;
  logic            w_load_en;
  logic            w_clr;
  logic            w_wt_full;
  logic            w_act_full;

  // An abort cycle accepts no beat, so the data/address outputs hold across the abort.
  assign w_load_en   = (r_state == LOAD) && !abort;
  assign w_clr       = abort || (r_state == IDLE);
  assign w_phase_end = (r_phase == '0);

  stream_addr_writer #(.DW(W_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wt_writer (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_load_en),
    .i_clr   (w_clr),
    .i_data  (w_data),
    .i_valid (w_valid),
    .o_ready (w_ready),
    .o_data  (Weight),
    .o_addr  (Weight_Mem_Address_in),
    .o_full  (w_wt_full)
  );

  stream_addr_writer #(.DW(A_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_act_writer (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_load_en),
    .i_clr   (w_clr),
    .i_data  (a_data),
    .i_valid (a_valid),
    .o_ready (a_ready),
    .o_data  (Activation),
    .o_addr  (Activation_Mem_Address_in),
    .o_full  (w_act_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Shared phase down-counter, reloaded whenever a new state is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_phase <= '0;
    else if (abort)              r_phase <= '0;
    else if (w_next != r_state)  r_phase <= phase_reload(w_next);
    else if (!w_phase_end)       r_phase <= r_phase - PH_W'(1);
  end

  // Next-state and phase control outputs decoded from the current state.
  always_comb begin
    w_next          = r_state;
    busy            = (r_state != IDLE);
    load_mem_done   = 1'b0;
    PreLoad_CWeight = 1'b0;
    Cal             = 1'b0;
    done            = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    if (w_wt_full && w_act_full) w_next = SETTLE;
      SETTLE: begin
        load_mem_done = 1'b1;
        if (w_phase_end) w_next = PRELOAD;
      end
      PRELOAD: begin
        load_mem_done   = 1'b1;
        PreLoad_CWeight = 1'b1;
        if (w_phase_end) w_next = CAL;
      end
      CAL: begin
        load_mem_done = 1'b1;
        Cal           = 1'b1;
        if (w_phase_end) w_next = FIN;
      end
      FIN: begin
        load_mem_done = 1'b1;
        done          = 1'b1;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

endmodule

// File: tb/tb_preload_sequencer.sv
// Randomised scoreboard bench for preload_sequencer.
module tb_preload_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] w_data = '0;
  logic       w_valid = 1'b0;
  logic       w_ready;
  logic [6:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] Weight;
  logic [5:0] Weight_Mem_Address_in;
  logic [6:0] Activation;
  logic [5:0] Activation_Mem_Address_in;
  logic       load_mem_done, PreLoad_CWeight, Cal, busy, done;

  int errors = 0;
  int checks = 0;

  preload_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .Weight(Weight), .Weight_Mem_Address_in(Weight_Mem_Address_in),
    .Activation(Activation), .Activation_Mem_Address_in(Activation_Mem_Address_in),
    .load_mem_done(load_mem_done), .PreLoad_CWeight(PreLoad_CWeight), .Cal(Cal),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Control vector encoding: {load_mem_done, PreLoad_CWeight, Cal, done}
  localparam logic [3:0] C_SETTLE = 4'b1000;
  localparam logic [3:0] C_PRE    = 4'b1100;
  localparam logic [3:0] C_CAL    = 4'b1010;
  localparam logic [3:0] C_FIN    = 4'b1001;

  bit         m_load = 0;
  int         mw = 0, ma = 0;
  logic [3:0] ctrl_q[$];
  int         wq[$], aq[$];
  int         w_hold = 0, a_hold = 0;
  logic [3:0] e_ctrl;
  bit         e_wr, e_ar;

  always @(negedge clk) begin
    if (!rst) begin
      m_load = 0; mw = 0; ma = 0;
      ctrl_q.delete(); wq.delete(); aq.delete();
      w_hold = 0; a_hold = 0;
    end else begin
      e_ctrl = (ctrl_q.size() > 0) ? ctrl_q[0] : 4'b0000;
      e_wr   = m_load && (mw < 64) && !abort;
      e_ar   = m_load && (ma < 64) && !abort;
      chk("busy", int'(busy), int'(m_load || ctrl_q.size() > 0));
      chk("ctrl", int'({load_mem_done, PreLoad_CWeight, Cal, done}), int'(e_ctrl));
      chk("pre_cal_excl", int'(PreLoad_CWeight && Cal), 0);
      chk("w_ready", int'(w_ready), int'(e_wr));
      chk("a_ready", int'(a_ready), int'(e_ar));
      if (wq.size() > 0) w_hold = wq.pop_front();
      if (aq.size() > 0) a_hold = aq.pop_front();
      chk("weight_pair", int'(Weight_Mem_Address_in) * 256 + int'(Weight), w_hold);
      chk("act_pair", int'(Activation_Mem_Address_in) * 128 + int'(Activation), a_hold);
      if (abort) begin
        m_load = 0; mw = 0; ma = 0;
        ctrl_q.delete();
      end else if (m_load) begin
        if (mw == 64 && ma == 64) begin
          m_load = 0;
          repeat (4)  ctrl_q.push_back(C_SETTLE);
          repeat (3)  ctrl_q.push_back(C_PRE);
          repeat (22) ctrl_q.push_back(C_CAL);
          ctrl_q.push_back(C_FIN);
        end else begin
          if (w_valid && e_wr) begin wq.push_back(mw * 256 + int'(w_data)); mw++; end
          if (a_valid && e_ar) begin aq.push_back(ma * 128 + int'(a_data)); ma++; end
        end
      end else if (ctrl_q.size() > 0) begin
        void'(ctrl_q.pop_front());
      end else if (start) begin
        m_load = 1; mw = 0; ma = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_tile();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic send_w(input int n, input int max_gap, input bit seq);
    for (int i = 0; i < n; i++) begin
      int gap;
      int tmo;
      bit acc;
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (gap) begin w_valid = 1'b0; cyc(); end
      w_valid = 1'b1;
      w_data  = seq ? 8'(i) : 8'($urandom_range(255, 0));
      tmo = 0; acc = 0;
      while (!acc && tmo < 500) begin
        @(negedge clk);
        acc = w_ready;
        cyc();
        tmo++;
      end
      if (!acc) begin chk("w_beat_timeout", 1, 0); break; end
    end
    w_valid = 1'b0;
  endtask

  task automatic send_a(input int n, input int max_gap, input bit seq);
    for (int i = 0; i < n; i++) begin
      int gap;
      int tmo;
      bit acc;
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (gap) begin a_valid = 1'b0; cyc(); end
      a_valid = 1'b1;
      a_data  = seq ? 7'(i) : 7'($urandom_range(127, 0));
      tmo = 0; acc = 0;
      while (!acc && tmo < 500) begin
        @(negedge clk);
        acc = a_ready;
        cyc();
        tmo++;
      end
      if (!acc) begin chk("a_beat_timeout", 1, 0); break; end
    end
    a_valid = 1'b0;
  endtask

  task automatic wait_idle(output int ndone);
    bit ok;
    ndone = 0; ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 1, 0);
    cyc();
  endtask

  task automatic wait_cal();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (Cal) begin ok = 1; break; end
    end
    if (!ok) chk("cal_timeout", 1, 0);
  endtask

  // ---------------- test sequence ----------------
  bit w_fin;
  int nd;

  initial begin
    repeat (2) cyc();
    chk("rst_busy", int'(busy), 0);
    chk("rst_ctrl", int'({load_mem_done, PreLoad_CWeight, Cal, done}), 0);
    chk("rst_weight", int'(Weight), 0);
    rst = 1'b1;
    cyc();

    // 1: async reset in the middle of LOAD
    start_tile();
    send_w(10, 0, 1);
    chk("t1_weight_before_rst", int'(Weight), 9);
    #3 rst = 1'b0;
    #1;
    chk("t1_busy", int'(busy), 0);
    chk("t1_ready", int'({w_ready, a_ready}), 0);
    chk("t1_weight", int'(Weight), 0);
    chk("t1_waddr", int'(Weight_Mem_Address_in), 0);
    chk("t1_act", int'({Activation_Mem_Address_in, Activation}), 0);
    chk("t1_ctrl", int'({load_mem_done, PreLoad_CWeight, Cal, done}), 0);
    cyc(); rst = 1'b1; cyc();

    // 2: back-to-back full tile, data equals address
    start_tile();
    fork
      send_w(64, 0, 1);
      send_a(64, 0, 1);
    join
    wait_idle(nd);
    chk("t2_done_count", nd, 1);

    // 3: random gaps, activations finish well after weights, 65th weight offered
    w_fin = 0;
    start_tile();
    fork
      begin
        send_w(64, 3, 0);
        w_fin = 1;
        w_valid = 1'b1; w_data = 8'hAA;
        repeat (40) begin
          @(negedge clk);
          chk("t3_w65_ready", int'(w_ready), 0);
          cyc();
        end
        w_valid = 1'b0;
      end
      begin
        int tmo;
        send_a(30, 2, 0);
        tmo = 0;
        while (!w_fin && tmo < 2000) begin cyc(); tmo++; end
        if (!w_fin) chk("t3_wfin_timeout", 1, 0);
        repeat (30) cyc();
        send_a(34, 1, 0);
      end
    join
    wait_idle(nd);
    chk("t3_done_count", nd, 1);

    // 4: abort in CAL cycle 5, then start+abort together in IDLE
    start_tile();
    fork
      send_w(64, 0, 0);
      send_a(64, 0, 0);
    join
    wait_cal();
    repeat (4) cyc();
    abort = 1'b1; cyc(); abort = 1'b0;
    @(negedge clk);
    chk("t4_cal_after_abort", int'(Cal), 0);
    chk("t4_busy_after_abort", int'(busy), 0);
    chk("t4_done_after_abort", int'(done), 0);
    cyc();
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("t4_start_abort_idle", int'(busy), 0);
    cyc();

    // 5: start during CAL is ignored
    start_tile();
    fork
      send_w(64, 1, 0);
      send_a(64, 1, 0);
    join
    wait_cal();
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    wait_idle(nd);
    chk("t5_done_count", nd, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t5_stays_idle", int'(busy), 0);
    end
    cyc();

    // extra random tiles
    repeat (2) begin
      start_tile();
      fork
        send_w(64, 4, 0);
        send_a(64, 4, 0);
      join
      wait_idle(nd);
      chk("rand_done_count", nd, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
